// File: rtl/id_ex_if.sv
// ID/EX stage bus: ID-side operands and control, MEM/WB forwarding sources,
// and the registered EX slot with its forwarded operands.
interface id_ex_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [11:0] id_ctrl;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [11:0] ex_ctrl;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_ctrl, flush, mem_reg_write, mem_rd, mem_alu_result,
               wb_reg_write, wb_rd, wb_data,
        input  stall, ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl,
               ex_op_a, ex_op_b
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_ctrl, flush, mem_reg_write, mem_rd, mem_alu_result,
               wb_reg_write, wb_rd, wb_data,
        output stall, ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl,
               ex_op_a, ex_op_b
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles,
// MEM/WB operand forwarding and saturating stall/flush counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    id_ex_if.slave           bus,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    // Control layout: {reg_write, mem_read, mem_write, mem_to_reg[1:0], alu_src, alu_op[5:0]}
    localparam int MEM_READ_BIT = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      imm_q, imm_d;
    logic [11:0]      ctrl_q, ctrl_d;
    logic [31:0]      rs_data_q, rs_data_d;
    logic [31:0]      rt_data_q, rt_data_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_in_ex;
    logic id_uses_load;
    logic stall_c;

    always_comb begin
        load_in_ex   = valid_q & ctrl_q[MEM_READ_BIT] & (rd_q != 5'd0);
        id_uses_load = bus.id_valid & ((rd_q == bus.id_rs) | (rd_q == bus.id_rt));
        stall_c      = load_in_ex & id_uses_load & ~bus.flush;
    end

    // Flush outranks stall; both load an all-zero bubble into the EX slot.
    always_comb begin
        valid_d       = 1'b0;
        pc_d          = '0;
        rs_d          = '0;
        rt_d          = '0;
        rd_d          = '0;
        imm_d         = '0;
        ctrl_d        = '0;
        rs_data_d     = '0;
        rt_data_d     = '0;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (bus.flush) begin
            if (flush_count_q != CNT_MAX) begin
                flush_count_d = flush_count_q + CNT_W'(1);
            end
        end else if (stall_c) begin
            if (stall_count_q != CNT_MAX) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end else begin
            valid_d   = bus.id_valid;
            pc_d      = bus.id_pc;
            rs_d      = bus.id_rs;
            rt_d      = bus.id_rt;
            rd_d      = bus.id_rd;
            imm_d     = bus.id_imm;
            ctrl_d    = bus.id_valid ? bus.id_ctrl : 12'h000;
            rs_data_d = bus.id_rs_data;
            rt_data_d = bus.id_rt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            ctrl_q        <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            ctrl_q        <= ctrl_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // The younger MEM result wins over WB; register 0 is never forwarded.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  src,
        input logic [31:0] held,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        logic [31:0] result;
        result = held;
        if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
            result = m_val;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
            result = w_val;
        end
        return result;
    endfunction

    assign bus.stall    = stall_c;
    assign bus.ex_valid = valid_q;
    assign bus.ex_pc    = pc_q;
    assign bus.ex_rs    = rs_q;
    assign bus.ex_rt    = rt_q;
    assign bus.ex_rd    = rd_q;
    assign bus.ex_imm   = imm_q;
    assign bus.ex_ctrl  = ctrl_q;
    assign bus.ex_op_a  = fwd_operand(rs_q, rs_data_q, bus.mem_reg_write, bus.mem_rd,
                                      bus.mem_alu_result, bus.wb_reg_write, bus.wb_rd,
                                      bus.wb_data);
    assign bus.ex_op_b  = fwd_operand(rt_q, rt_data_q, bus.mem_reg_write, bus.mem_rd,
                                      bus.mem_alu_result, bus.wb_reg_write, bus.wb_rd,
                                      bus.wb_data);
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset-mid-stream sequence and a
// randomized run against a slot-level model; a CNT_W=2 copy covers saturation.
module tb_id_ex_stage;
    localparam logic [11:0] ALU = 12'h801;
    localparam logic [11:0] LW  = 12'hC00;

    logic        clk;
    logic        reset;
    logic [15:0] stall_count, flush_count;
    logic [1:0]  stall_count_s, flush_count_s;
    int          n_checks = 0;
    int          n_fail   = 0;

    id_ex_if bus ();
    id_ex_if bus_s ();

    id_ex_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s),
        .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    assign bus_s.id_valid       = bus.id_valid;
    assign bus_s.id_pc          = bus.id_pc;
    assign bus_s.id_rs          = bus.id_rs;
    assign bus_s.id_rt          = bus.id_rt;
    assign bus_s.id_rd          = bus.id_rd;
    assign bus_s.id_rs_data     = bus.id_rs_data;
    assign bus_s.id_rt_data     = bus.id_rt_data;
    assign bus_s.id_imm         = bus.id_imm;
    assign bus_s.id_ctrl        = bus.id_ctrl;
    assign bus_s.flush          = bus.flush;
    assign bus_s.mem_reg_write  = bus.mem_reg_write;
    assign bus_s.mem_rd         = bus.mem_rd;
    assign bus_s.mem_alu_result = bus.mem_alu_result;
    assign bus_s.wb_reg_write   = bus.wb_reg_write;
    assign bus_s.wb_rd          = bus.wb_rd;
    assign bus_s.wb_data        = bus.wb_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [11:0] ctrl;
        logic        fl;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        e_stall;
        logic        e_valid;
        logic [11:0] e_ctrl;
        logic [31:0] e_op_a, e_op_b;
        int          e_scnt, e_fcnt, e_scnt_s;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [11:0] ctrl;
        logic [31:0] rs_data, rt_data;
    } slot_t;

    vec_t  vecs[$];
    slot_t m_ex;
    int    m_stalls;
    int    m_flushes;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_ctrl = 0;
        bus.flush = 0; bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_alu_result = 0;
        bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.id_valid = v.v; bus.id_pc = v.pc; bus.id_rs = v.rs; bus.id_rt = v.rt;
        bus.id_rd = v.rd; bus.id_rs_data = v.rs_data; bus.id_rt_data = v.rt_data;
        bus.id_imm = v.imm; bus.id_ctrl = v.ctrl; bus.flush = v.fl;
        bus.mem_reg_write = v.mrw; bus.mem_rd = v.mrd; bus.mem_alu_result = v.mres;
        bus.wb_reg_write = v.wrw; bus.wb_rd = v.wrd; bus.wb_data = v.wdat;
    endtask

    task automatic randomInputs();
        logic [11:0] c;
        c = 12'($urandom);
        if ($urandom_range(0, 1) == 1) c[10] = 1'b1;
        bus.id_valid       = ($urandom_range(0, 6) != 0);
        bus.id_pc          = $urandom;
        bus.id_rs          = 5'($urandom_range(0, 7));
        bus.id_rt          = 5'($urandom_range(0, 7));
        bus.id_rd          = 5'($urandom_range(0, 7));
        bus.id_rs_data     = $urandom;
        bus.id_rt_data     = $urandom;
        bus.id_imm         = $urandom;
        bus.id_ctrl        = c;
        bus.flush          = ($urandom_range(0, 9) == 0);
        bus.mem_reg_write  = 1'($urandom_range(0, 1));
        bus.mem_rd         = 5'($urandom_range(0, 7));
        bus.mem_alu_result = $urandom;
        bus.wb_reg_write   = 1'($urandom_range(0, 1));
        bus.wb_rd          = 5'($urandom_range(0, 7));
        bus.wb_data        = $urandom;
    endtask

    // Model: a consumer must wait while a load sits in EX; saturating counters are min(events, max).
    function automatic logic m_load_use();
        return !bus.flush && m_ex.valid && m_ex.ctrl[10] && (m_ex.rd != 0) && bus.id_valid &&
               ((m_ex.rd == bus.id_rs) || (m_ex.rd == bus.id_rt));
    endfunction

    function automatic int sat(input int events, input int width);
        int mx;
        mx = (1 << width) - 1;
        return (events > mx) ? mx : events;
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] src, input logic [31:0] held);
        if (src == 0) return held;
        if (bus.mem_reg_write && bus.mem_rd == src) return bus.mem_alu_result;
        if (bus.wb_reg_write && bus.wb_rd == src) return bus.wb_data;
        return held;
    endfunction

    task automatic modelClock();
        logic hz;
        hz = m_load_use();
        if (bus.flush) begin
            m_ex = '{default: '0};
            m_flushes++;
        end else if (hz) begin
            m_ex = '{default: '0};
            m_stalls++;
        end else begin
            m_ex.valid   = bus.id_valid;
            m_ex.pc      = bus.id_pc;
            m_ex.rs      = bus.id_rs;
            m_ex.rt      = bus.id_rt;
            m_ex.rd      = bus.id_rd;
            m_ex.imm     = bus.id_imm;
            m_ex.ctrl    = bus.id_valid ? bus.id_ctrl : 12'h000;
            m_ex.rs_data = bus.id_rs_data;
            m_ex.rt_data = bus.id_rt_data;
        end
    endtask

    task automatic checkModel(input int cyc);
        logic [31:0] ea, eb;
        ea = m_operand(m_ex.rs, m_ex.rs_data);
        eb = m_operand(m_ex.rt, m_ex.rt_data);
        checkOutput($sformatf("rnd%0d stall", cyc), 32'(bus.stall), 32'(m_load_use()));
        checkOutput($sformatf("rnd%0d ex_valid", cyc), 32'(bus.ex_valid), 32'(m_ex.valid));
        checkOutput($sformatf("rnd%0d ex_pc", cyc), bus.ex_pc, m_ex.pc);
        checkOutput($sformatf("rnd%0d ex_rs", cyc), 32'(bus.ex_rs), 32'(m_ex.rs));
        checkOutput($sformatf("rnd%0d ex_rt", cyc), 32'(bus.ex_rt), 32'(m_ex.rt));
        checkOutput($sformatf("rnd%0d ex_rd", cyc), 32'(bus.ex_rd), 32'(m_ex.rd));
        checkOutput($sformatf("rnd%0d ex_imm", cyc), bus.ex_imm, m_ex.imm);
        checkOutput($sformatf("rnd%0d ex_ctrl", cyc), 32'(bus.ex_ctrl), 32'(m_ex.ctrl));
        checkOutput($sformatf("rnd%0d ex_op_a", cyc), bus.ex_op_a, ea);
        checkOutput($sformatf("rnd%0d ex_op_b", cyc), bus.ex_op_b, eb);
        checkOutput($sformatf("rnd%0d stall_count", cyc), 32'(stall_count), 32'(sat(m_stalls, 16)));
        checkOutput($sformatf("rnd%0d flush_count", cyc), 32'(flush_count), 32'(sat(m_flushes, 16)));
        checkOutput($sformatf("rnd%0d s.stall", cyc), 32'(bus_s.stall), 32'(m_load_use()));
        checkOutput($sformatf("rnd%0d s.ex_valid", cyc), 32'(bus_s.ex_valid), 32'(m_ex.valid));
        checkOutput($sformatf("rnd%0d s.ex_pc", cyc), bus_s.ex_pc, m_ex.pc);
        checkOutput($sformatf("rnd%0d s.ex_rs", cyc), 32'(bus_s.ex_rs), 32'(m_ex.rs));
        checkOutput($sformatf("rnd%0d s.ex_rt", cyc), 32'(bus_s.ex_rt), 32'(m_ex.rt));
        checkOutput($sformatf("rnd%0d s.ex_rd", cyc), 32'(bus_s.ex_rd), 32'(m_ex.rd));
        checkOutput($sformatf("rnd%0d s.ex_imm", cyc), bus_s.ex_imm, m_ex.imm);
        checkOutput($sformatf("rnd%0d s.ex_ctrl", cyc), 32'(bus_s.ex_ctrl), 32'(m_ex.ctrl));
        checkOutput($sformatf("rnd%0d s.ex_op_a", cyc), bus_s.ex_op_a, ea);
        checkOutput($sformatf("rnd%0d s.ex_op_b", cyc), bus_s.ex_op_b, eb);
        checkOutput($sformatf("rnd%0d s.stall_count", cyc), 32'(stall_count_s), 32'(sat(m_stalls, 2)));
        checkOutput($sformatf("rnd%0d s.flush_count", cyc), 32'(flush_count_s), 32'(sat(m_flushes, 2)));
    endtask

    initial begin
        // {v,pc,rs,rt,rd,rs_data,rt_data,imm,ctrl,flush, mrw,mrd,mres, wrw,wrd,wdat,
        //  e_stall,e_valid,e_ctrl,e_op_a,e_op_b,e_scnt,e_fcnt,e_scnt_s}
        vecs.push_back('{1,32'h04,3,4,6,32'h1234,32'h5678,32'h10,ALU,0, 0,0,0, 0,0,0, 0,1,ALU,32'h1234,32'h5678,0,0,0});
        vecs.push_back('{1,32'h08,1,2,5,32'h11,32'h22,32'h4,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,0,0,0});
        vecs.push_back('{1,32'h0C,8,5,9,32'h88,32'h99,0,ALU,0, 1,5,32'h100, 0,0,0, 1,0,0,0,0,1,0,1});
        vecs.push_back('{1,32'h0C,8,5,9,32'h88,32'h99,0,ALU,0, 0,0,0, 1,5,32'hCAFE, 0,1,ALU,32'h88,32'hCAFE,1,0,1});
        vecs.push_back('{1,32'h10,7,0,3,32'h77,32'h55,0,ALU,0, 1,7,32'hA, 1,7,32'hB, 0,1,ALU,32'hA,32'h55,1,0,1});
        vecs.push_back('{1,32'h10,7,0,3,32'h77,32'h55,0,ALU,0, 0,7,32'hA, 1,7,32'hB, 0,1,ALU,32'hB,32'h55,1,0,1});
        vecs.push_back('{1,32'h14,0,0,3,32'h66,32'h55,0,ALU,0, 1,0,32'hA, 1,0,32'hB, 0,1,ALU,32'h66,32'h55,1,0,1});
        vecs.push_back('{1,32'h18,1,2,5,32'h11,32'h22,0,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,1,0,1});
        vecs.push_back('{1,32'h1C,5,0,9,32'h88,32'h99,0,ALU,1, 0,0,0, 0,0,0, 0,0,0,0,0,1,1,1});
        vecs.push_back('{0,32'h20,3,4,6,32'h33,32'h44,0,ALU,0, 0,0,0, 0,0,0, 0,0,0,32'h33,32'h44,1,1,1});
        vecs.push_back('{1,32'h24,1,2,5,32'h11,32'h22,0,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,1,1,1});
        vecs.push_back('{1,32'h28,8,5,9,32'h88,32'h99,0,ALU,0, 0,0,0, 0,0,0, 1,0,0,0,0,2,1,2});
        vecs.push_back('{1,32'h2C,1,2,5,32'h11,32'h22,0,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,2,1,2});
        vecs.push_back('{1,32'h30,8,5,9,32'h88,32'h99,0,ALU,0, 0,0,0, 0,0,0, 1,0,0,0,0,3,1,3});
        vecs.push_back('{1,32'h34,1,2,5,32'h11,32'h22,0,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,3,1,3});
        vecs.push_back('{1,32'h38,8,5,9,32'h88,32'h99,0,ALU,0, 0,0,0, 0,0,0, 1,0,0,0,0,4,1,3});
        vecs.push_back('{1,32'h3C,1,2,5,32'h11,32'h22,0,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,4,1,3});
        vecs.push_back('{1,32'h40,8,5,9,32'h88,32'h99,0,ALU,0, 0,0,0, 0,0,0, 1,0,0,0,0,5,1,3});
        vecs.push_back('{1,32'h48,1,2,0,32'h11,32'h22,0,LW,0, 0,0,0, 0,0,0, 0,1,LW,32'h11,32'h22,5,1,3});
        vecs.push_back('{1,32'h4C,0,0,9,32'h88,32'h99,0,ALU,0, 0,0,0, 0,0,0, 0,1,ALU,32'h88,32'h99,5,1,3});

        reset = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset ex_valid", 32'(bus.ex_valid), 32'h0);
        checkOutput("reset ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
        checkOutput("reset ex_op_a", bus.ex_op_a, 32'h0);
        checkOutput("reset stall", 32'(bus.stall), 32'h0);
        checkOutput("reset stall_count", 32'(stall_count), 32'h0);
        checkOutput("reset flush_count", 32'(flush_count), 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d ex_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d ex_ctrl", i), 32'(bus.ex_ctrl), 32'(vecs[i].e_ctrl));
            checkOutput($sformatf("vec%0d ex_op_a", i), bus.ex_op_a, vecs[i].e_op_a);
            checkOutput($sformatf("vec%0d ex_op_b", i), bus.ex_op_b, vecs[i].e_op_b);
            checkOutput($sformatf("vec%0d stall_count", i), 32'(stall_count), 32'(vecs[i].e_scnt));
            checkOutput($sformatf("vec%0d flush_count", i), 32'(flush_count), 32'(vecs[i].e_fcnt));
            checkOutput($sformatf("vec%0d small stall_count", i), 32'(stall_count_s), 32'(vecs[i].e_scnt_s));
        end

        // Reset mid-cycle while EX holds a live instruction must clear at once.
        idleInputs();
        bus.id_valid = 1; bus.id_rs = 2; bus.id_rd = 5; bus.id_ctrl = 12'hFFF;
        @(posedge clk);
        #1;
        checkOutput("preReset ex_ctrl", 32'(bus.ex_ctrl), 32'hFFF);
        idleInputs();
        #1 reset = 1'b1;
        #1;
        checkOutput("midReset ex_valid", 32'(bus.ex_valid), 32'h0);
        checkOutput("midReset ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
        checkOutput("midReset ex_rd", 32'(bus.ex_rd), 32'h0);
        checkOutput("midReset stall_count", 32'(stall_count), 32'h0);
        checkOutput("midReset flush_count", 32'(flush_count), 32'h0);
        #1 reset = 1'b0;
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rs_data = 32'h1234; bus.id_ctrl = ALU;
        @(negedge clk);
        checkOutput("postReset stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("postReset ex_valid", 32'(bus.ex_valid), 32'h1);
        checkOutput("postReset ex_rs", 32'(bus.ex_rs), 32'h3);
        checkOutput("postReset ex_op_a", bus.ex_op_a, 32'h1234);
        checkOutput("postReset ex_ctrl", 32'(bus.ex_ctrl), 32'(ALU));

        reset = 1'b1;
        idleInputs();
        @(posedge clk);
        #1 reset = 1'b0;
        m_ex      = '{default: '0};
        m_stalls  = 0;
        m_flushes = 0;
        for (int c = 0; c < 300; c++) begin
            randomInputs();
            @(negedge clk);
            checkModel(c);
            @(posedge clk);
            modelClock();
            #1;
        end
        $display("[TB] random run saw %0d stalls and %0d flushes", m_stalls, m_flushes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
